// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: accepts one writeback or interrupt event in IDLE, then
// strobes the CSR file, flushes the pipeline and redirects fetch to the trap or return vector.
module trap_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [XLEN-1:0]    wb_pc,
    input  logic [XLEN-1:0]    wb_next_pc,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic               mret_req,
    input  logic               eip,
    input  logic               tip,
    input  logic               sip,
    input  logic [XLEN-1:0]    trap_vector,
    input  logic [XLEN-1:0]    mret_vector,
    input  logic               flush_ack,
    input  logic               redirect_ready,
    output logic               traped,
    output logic               mret,
    output logic [XLEN-1:0]    ecp,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic               interupt,
    output logic               retired,
    output logic               wb_stall,
    output logic               flush_req,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedirect} state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    ecp_q, ecp_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               intr_q, intr_d;
    logic               is_mret_q, is_mret_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

    always_comb begin
        state_d       = state_q;
        ecp_d         = ecp_q;
        cause_d       = cause_q;
        intr_d        = intr_q;
        is_mret_d     = is_mret_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (wb_valid) begin
                    if (exc_valid) begin
                        state_d   = StCommit;
                        ecp_d     = wb_pc;
                        cause_d   = exc_cause;
                        intr_d    = 1'b0;
                        is_mret_d = 1'b0;
                    end else if (mret_req) begin
                        // mepc captured now, before the CSR file applies the mret update
                        state_d       = StCommit;
                        is_mret_d     = 1'b1;
                        redirect_pc_d = mret_vector;
                    end else if (eip || sip || tip) begin
                        state_d   = StCommit;
                        ecp_d     = wb_next_pc;
                        intr_d    = 1'b1;
                        is_mret_d = 1'b0;
                        if (eip) begin
                            cause_d = CAUSE_W'(11);
                        end else if (sip) begin
                            cause_d = CAUSE_W'(3);
                        end else begin
                            cause_d = CAUSE_W'(7);
                        end
                    end
                end
            end
            StCommit: begin
                state_d = StFlush;
                if (!is_mret_q) begin
                    redirect_pc_d = trap_vector;
                end
            end
            StFlush: begin
                if (flush_ack) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            ecp_q         <= '0;
            cause_q       <= '0;
            intr_q        <= 1'b0;
            is_mret_q     <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            ecp_q         <= ecp_d;
            cause_q       <= cause_d;
            intr_q        <= intr_d;
            is_mret_q     <= is_mret_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        traped         = (state_q == StCommit) && !is_mret_q;
        mret           = (state_q == StCommit) && is_mret_q;
        ecp            = ecp_q;
        trap_cause     = cause_q;
        interupt       = intr_q;
        retired        = wb_valid && !exc_valid && (state_q == StIdle);
        wb_stall       = (state_q != StIdle);
        flush_req      = (state_q == StCommit) || (state_q == StFlush);
        redirect_valid = (state_q == StRedirect);
        redirect_pc    = redirect_pc_q;
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: table of single-event vectors walked through the full
// sequence, plus hand sequences for backpressure, mid-sequence reset and gated interrupts.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, exc_valid, mret_req, eip, tip, sip;
    logic [31:0] wb_pc, wb_next_pc, trap_vector, mret_vector;
    logic [3:0]  exc_cause;
    logic        flush_ack, redirect_ready;
    logic        traped, mret, interupt, retired, wb_stall, flush_req, redirect_valid;
    logic [31:0] ecp, redirect_pc;
    logic [3:0]  trap_cause;

    int checks = 0;
    int failures = 0;

    trap_sequencer #(.XLEN(32), .CAUSE_W(4)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .mret_req(mret_req), .eip(eip),
        .tip(tip), .sip(sip), .trap_vector(trap_vector), .mret_vector(mret_vector),
        .flush_ack(flush_ack), .redirect_ready(redirect_ready), .traped(traped), .mret(mret),
        .ecp(ecp), .trap_cause(trap_cause), .interupt(interupt), .retired(retired),
        .wb_stall(wb_stall), .flush_req(flush_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // kind: 0 = no acceptance, 1 = trap, 2 = mret
    typedef struct {
        logic        wb_valid, exc_valid, mret_req, eip, tip, sip;
        logic [3:0]  exc_cause;
        logic [31:0] wb_pc, wb_next_pc;
        int          kind;
        logic        retired;
        logic [3:0]  cause;
        logic        intr;
        logic [31:0] ecp, rpc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wb_valid = 0; exc_valid = 0; mret_req = 0; eip = 0; tip = 0; sip = 0;
        exc_cause = 0; wb_pc = 0; wb_next_pc = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered and left #1 after a posedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        wb_valid = v.wb_valid; exc_valid = v.exc_valid; mret_req = v.mret_req;
        eip = v.eip; tip = v.tip; sip = v.sip; exc_cause = v.exc_cause;
        wb_pc = v.wb_pc; wb_next_pc = v.wb_next_pc;
        trap_vector = 32'hDEAD; mret_vector = 32'h300;
        flush_ack = 1; redirect_ready = 1;
        @(negedge clk);
        chk({tag, " retired"}, 32'(retired), 32'(v.retired));
        chk({tag, " idle stall"}, 32'(wb_stall), 0);
        next_cycle();
        clear_inputs();
        trap_vector = 32'h80; mret_vector = 32'hBAD0;
        @(negedge clk);
        if (v.kind == 0) begin
            chk({tag, " no strobe"}, 32'({traped, mret, wb_stall}), 0);
            next_cycle();
            return;
        end
        chk({tag, " strobes"}, 32'({traped, mret}), (v.kind == 1) ? 32'h2 : 32'h1);
        chk({tag, " commit flush/stall"}, 32'({flush_req, wb_stall}), 32'h3);
        if (v.kind == 1) begin
            chk({tag, " ecp"}, ecp, v.ecp);
            chk({tag, " cause"}, 32'(trap_cause), 32'(v.cause));
            chk({tag, " interupt"}, 32'(interupt), 32'(v.intr));
        end
        next_cycle();
        @(negedge clk);
        chk({tag, " flush state"}, 32'({flush_req, redirect_valid, traped, mret}), 32'h8);
        next_cycle();
        @(negedge clk);
        chk({tag, " redirect state"}, 32'({redirect_valid, flush_req, wb_stall}), 32'h5);
        chk({tag, " redirect_pc"}, redirect_pc, v.rpc);
        next_cycle();
        @(negedge clk);
        chk({tag, " back to idle"}, 32'({wb_stall, redirect_valid}), 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k, idle_k, n_mret, n_trap, n_flush, n_redir, n_badpc, bad;
        //        wbv exc mret eip tip sip cause pc         next_pc    kind ret cause intr ecp  rpc
        vecs[0] = '{1, 1, 0, 0, 0, 0, 4'd2, 32'h100, 32'h104, 1, 0, 4'd2,  0, 32'h100, 32'h80};
        vecs[1] = '{1, 1, 1, 1, 0, 0, 4'd5, 32'h200, 32'h204, 1, 0, 4'd5,  0, 32'h200, 32'h80};
        vecs[2] = '{1, 0, 0, 1, 1, 1, 4'd0, 32'h40,  32'h44,  1, 1, 4'd11, 1, 32'h44,  32'h80};
        vecs[3] = '{1, 0, 0, 0, 1, 1, 4'd0, 32'h44,  32'h48,  1, 1, 4'd3,  1, 32'h48,  32'h80};
        vecs[4] = '{1, 0, 0, 0, 1, 0, 4'd0, 32'h48,  32'h4c,  1, 1, 4'd7,  1, 32'h4c,  32'h80};
        vecs[5] = '{1, 0, 1, 0, 0, 0, 4'd0, 32'h60,  32'h64,  2, 1, 4'd0,  0, 32'h0,   32'h300};
        vecs[6] = '{0, 1, 0, 1, 0, 0, 4'd3, 32'h70,  32'h74,  0, 0, 4'd0,  0, 32'h0,   32'h0};
        vecs[7] = '{1, 0, 0, 0, 0, 0, 4'd0, 32'h80,  32'h84,  0, 1, 4'd0,  0, 32'h0,   32'h0};

        clear_inputs();
        reset = 0; trap_vector = 32'h80; mret_vector = 32'h300;
        flush_ack = 1; redirect_ready = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset strobes/ctl", 32'({traped, mret, interupt, retired, wb_stall, flush_req,
            redirect_valid}), 0);
        chk("reset ecp", ecp, 0);
        chk("reset cause", 32'(trap_cause), 0);
        chk("reset redirect_pc", redirect_pc, 0);
        next_cycle();
        reset = 1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // mret under flush and redirect backpressure
        wb_valid = 1; mret_req = 1; mret_vector = 32'h300; flush_ack = 0; redirect_ready = 0;
        @(negedge clk);
        next_cycle();
        clear_inputs();
        mret_vector = 32'hBAD0;
        idle_k = 0; n_mret = 0; n_trap = 0; n_flush = 0; n_redir = 0; n_badpc = 0;
        for (k = 1; k <= 30; k++) begin
            flush_ack = (k >= 6);
            redirect_ready = (k >= 9);
            @(negedge clk);
            if (!wb_stall) begin
                idle_k = k;
                break;
            end
            n_mret += int'(mret);
            n_trap += int'(traped);
            n_flush += int'(flush_req);
            if (redirect_valid) begin
                n_redir++;
                if (redirect_pc !== 32'h300) n_badpc++;
            end
            next_cycle();
        end
        chk("bp mret pulses", n_mret, 1);
        chk("bp trap pulses", n_trap, 0);
        chk("bp flush cycles", n_flush, 6);
        chk("bp redirect cycles", n_redir, 3);
        chk("bp redirect_pc stable", n_badpc, 0);
        chk("bp idle cycle", idle_k, 10);
        next_cycle();

        // reset while in FLUSH
        wb_valid = 1; exc_valid = 1; exc_cause = 1; wb_pc = 32'h700; flush_ack = 0;
        redirect_ready = 1;
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chk("pre-reset in flush", 32'({flush_req, traped}), 32'h2);
        reset = 0;
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("rst mid strobes/ctl", 32'({traped, mret, interupt, wb_stall, flush_req,
            redirect_valid}), 0);
        chk("rst mid ecp", ecp, 0);
        chk("rst mid cause/pc", 32'(trap_cause) | redirect_pc, 0);
        next_cycle();
        run_vec(vecs[0], "post-reset");

        // tip pending without writeback must not be taken
        tip = 1; wb_next_pc = 32'h500;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad += int'(wb_stall | traped | flush_req);
            next_cycle();
        end
        chk("tip no wb_valid", bad, 0);
        run_vec('{1, 0, 0, 0, 1, 0, 4'd0, 32'h4fc, 32'h500, 1, 1, 4'd7, 1, 32'h500, 32'h80},
            "tip with wb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
